bus_mapper_pl: RTL and testbench

Parametrised, registered successor to the combinational CPU address decoder. It decodes a CPU request into per-device write strobes and returns read data through a registered read path with a ready/valid handshake. Memory-class regions can have a read latency of several cycles, and the I/O region has a configurable number of registers. It sits between the CPU data port and the screen memory, data memory, 7-segment display and I/O peripherals (keyboard, accelerometer, sound, lights).

---
 rtl/bus_mapper_pl.sv | 167 ++++++++++++++++
 tb/tb_bus_mapper_pl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bus_mapper_pl.sv
// Registered CPU bus mapper: decodes requests into per-device write strobes and returns read data.
// Latency: writes complete in the accept cycle; reads raise cpu_rvalid 1 cycle (seg/I/O) or MEM_LAT+1 cycles (dmem/smem) after accept.
// Backpressure: cpu_ready is low while a read is outstanding; the CPU holds cpu_req until accepted. Optional BUS_ERR_EN adds bus_err.
module bus_mapper_pl #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int SEL_LO  = 16,
    parameter int IDX_LO  = 2,
    parameter int NUM_IO  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [AW-1:0]        cpu_addr,
    output logic                 cpu_ready,
    output logic                 cpu_rvalid,
    output logic [DW-1:0]        cpu_readdata,
    output logic                 seg_wr,
    output logic                 dmem_wr,
    output logic                 smem_wr,
    output logic [NUM_IO-1:0]    io_wr,
    input  logic [DW-1:0]        dmem_readdata,
    input  logic [DW-1:0]        smem_readdata,
    input  logic [NUM_IO*DW-1:0] io_rdata
`ifdef BUS_ERR_EN
    ,
    output logic                 bus_err
`endif
);

    localparam int IDXW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    // Counter wide enough for MEM_LAT-1 up to 7.
    localparam int CW   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MWAIT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_region;

    logic [1:0]        w_region;
    logic [IDXW-1:0]   w_idx;
    logic              w_accept;
    logic              w_acc_wr;
    logic              w_acc_rd;
    logic              w_is_mem;
    logic              w_seg_ok;
    logic              w_io_ok;
    logic [NUM_IO-1:0] w_io_dec;
    logic [DW-1:0]     w_io_rd;
    logic [DW-1:0]     w_fast_rdata;
    logic [DW-1:0]     w_mem_rdata;
    logic              w_unused;

    assign w_region = cpu_addr[SEL_LO+1:SEL_LO];
    assign w_idx    = cpu_addr[IDX_LO+IDXW-1:IDX_LO];
    // Only the region and index fields take part in decoding.
    assign w_unused = ^cpu_addr;

    // Gating with reset_n keeps every strobe low while reset is asserted,
    // even though the CPU may be presenting a write at that time.
    assign cpu_ready = (r_state == IDLE);
    assign w_accept  = cpu_req & cpu_ready & reset_n;
    assign w_acc_wr  = w_accept & cpu_wr;
    assign w_acc_rd  = w_accept & ~cpu_wr;
    assign w_is_mem  = (w_region == 2'b01) | (w_region == 2'b10);
    assign w_seg_ok  = (w_idx == '0);

    // I/O index decode: one-hot hit vector plus the matching read word (0 when no register matches).
    always_comb begin
        w_io_dec = '0;
        w_io_rd  = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            if (w_idx == IDXW'(i)) begin
                w_io_dec[i] = 1'b1;
                w_io_rd     = io_rdata[i*DW +: DW];
            end
        end
    end

    assign w_io_ok = |w_io_dec;

    assign seg_wr  = w_acc_wr & (w_region == 2'b00) & w_seg_ok;
    assign dmem_wr = w_acc_wr & (w_region == 2'b01);
    assign smem_wr = w_acc_wr & (w_region == 2'b10);
    assign io_wr   = {NUM_IO{w_acc_wr & (w_region == 2'b11)}} & w_io_dec;

    // Seg is write-only and unmapped I/O indices yield 0 via the default of w_io_rd.
    assign w_fast_rdata = (w_region == 2'b11) ? w_io_rd : '0;
    // Memory source follows the captured region so the CPU may change cpu_addr during the wait.
    assign w_mem_rdata  = (r_region == 2'b10) ? smem_readdata : dmem_readdata;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: RESP is the single cycle in which cpu_rvalid is presented.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc_rd) w_next = w_is_mem ? MWAIT : RESP;
            MWAIT:   if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read datapath: data and rvalid are registered on the edge that enters RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_region     <= 2'b00;
            cpu_readdata <= '0;
            cpu_rvalid   <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            if (w_acc_rd) begin
                r_region <= w_region;
                if (w_is_mem) begin
                    r_cnt <= CW'(MEM_LAT - 1);
                end else begin
                    cpu_readdata <= w_fast_rdata;
                    cpu_rvalid   <= 1'b1;
                end
            end else if (r_state == MWAIT) begin
                if (r_cnt == '0) begin
                    cpu_readdata <= w_mem_rdata;
                    cpu_rvalid   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

`ifdef BUS_ERR_EN
    logic w_unmapped;
    logic r_bus_err;

    assign w_unmapped = ((w_region == 2'b00) & ~w_seg_ok) |
                        ((w_region == 2'b11) & ~w_io_ok);

    // Error pulse: for unmapped reads it coincides with cpu_rvalid, for unmapped writes it follows the accept edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_accept & w_unmapped;
        end
    end

    assign bus_err = r_bus_err;
`endif

endmodule

// File: tb/tb_bus_mapper_pl.sv
module tb_bus_mapper_pl;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int NUM_IO  = 4;
    localparam int MEM_LAT = 3;

    logic                 clk;
    logic                 reset_n;
    logic                 cpu_req;
    logic                 cpu_wr;
    logic [AW-1:0]        cpu_addr;
    logic                 cpu_ready;
    logic                 cpu_rvalid;
    logic [DW-1:0]        cpu_readdata;
    logic                 seg_wr;
    logic                 dmem_wr;
    logic                 smem_wr;
    logic [NUM_IO-1:0]    io_wr;
    logic [DW-1:0]        dmem_readdata;
    logic [DW-1:0]        smem_readdata;
    logic [NUM_IO*DW-1:0] io_rdata;
`ifdef BUS_ERR_EN
    logic                 bus_err;
`endif

    logic [6:0] strb;
    assign strb = {seg_wr, dmem_wr, smem_wr, io_wr};

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    bus_mapper_pl #(
        .DW(DW), .AW(AW), .SEL_LO(16), .IDX_LO(2), .NUM_IO(NUM_IO), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_req       (cpu_req),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_ready     (cpu_ready),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_readdata  (cpu_readdata),
        .seg_wr        (seg_wr),
        .dmem_wr       (dmem_wr),
        .smem_wr       (smem_wr),
        .io_wr         (io_wr),
        .dmem_readdata (dmem_readdata),
        .smem_readdata (smem_readdata),
        .io_rdata      (io_rdata)
`ifdef BUS_ERR_EN
        ,
        .bus_err       (bus_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr,
                            input logic [6:0] exp_strb, input logic exp_err);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = addr;
        @(negedge clk);
        chk({tag, "_strobe"}, strb, exp_strb);
        chk({tag, "_ready"}, cpu_ready, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        chk({tag, "_strobe_off"}, strb, 0);
`ifdef BUS_ERR_EN
        chk({tag, "_bus_err"}, bus_err, exp_err);
`else
        if (exp_err) chk({tag, "_no_err_port_ready"}, cpu_ready, 1);
`endif
    endtask

    // Expected data is queued at issue; the response is popped when cpu_rvalid appears.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                           input int exp_lat, input logic [31:0] addr_after, input logic exp_err);
        int lat, low, nval;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
        @(negedge clk);
        chk({tag, "_ready_at_accept"}, cpu_ready, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_addr = addr_after;
        lat = 0; low = 0; nval = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!cpu_ready) low++;
            if (cpu_rvalid) begin
                nval++;
                if (nval == 1) begin
                    lat = k;
                    chk({tag, "_data"}, cpu_readdata, exp_q.pop_front());
`ifdef BUS_ERR_EN
                    chk({tag, "_bus_err"}, bus_err, exp_err);
`else
                    if (exp_err) chk({tag, "_unmapped_zero"}, cpu_readdata, 0);
`endif
                end
            end
            if (nval > 0 && cpu_ready) break;
        end
        chk({tag, "_rvalid_count"}, nval, 1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_ready_low_cycles"}, low, exp_lat);
    endtask

    initial begin
        int nv;
        reset_n       = 1'b0;
        cpu_req       = 1'b1;
        cpu_wr        = 1'b1;
        cpu_addr      = 32'h0;
        dmem_readdata = 32'h1234_5678;
        smem_readdata = 32'hCAFE_F00D;
        io_rdata      = '0;
        io_rdata[0*DW +: DW] = 32'h0BAD_F00D;
        io_rdata[1*DW +: DW] = 32'hDEAD_BEEF;
        io_rdata[3*DW +: DW] = 32'hA5A5_3C3C;

        // Reset held with a write request pending: nothing may leak out.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_strobe", strb, 0);
            chk("rst_rdata", cpu_readdata, 0);
            chk("rst_rvalid", cpu_rvalid, 0);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", cpu_ready, 1);
        chk("rst_rvalid_after", cpu_rvalid, 0);

        do_write("wr_seg",  32'h0000_0000, 7'b1000000, 1'b0);
        do_write("wr_dmem", 32'h0001_0040, 7'b0100000, 1'b0);
        do_write("wr_smem", 32'h0002_0000, 7'b0010000, 1'b0);
        do_write("wr_io3",  32'h0003_000C, 7'b0001000, 1'b0);
        do_write("wr_io0",  32'h0003_0000, 7'b0000001, 1'b0);
        do_write("wr_unmap", 32'h0000_0004, 7'b0000000, 1'b1);

        do_read("rd_io1",  32'h0003_0004, 32'hDEAD_BEEF, 1, 32'h0003_0004, 1'b0);
        do_read("rd_io3",  32'h0003_000C, 32'hA5A5_3C3C, 1, 32'h0000_0000, 1'b0);
        do_read("rd_dmem", 32'h0001_0000, 32'h1234_5678, MEM_LAT + 1, 32'h0003_0000, 1'b0);
        do_read("rd_smem", 32'h0002_0010, 32'hCAFE_F00D, MEM_LAT + 1, 32'h0001_0000, 1'b0);
        do_read("rd_seg",  32'h0000_0000, 32'h0, 1, 32'h0, 1'b0);
        do_read("rd_unmap", 32'h0000_0004, 32'h0, 1, 32'h0, 1'b1);

        // Reset pulse during MWAIT must abort the read.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0001_0000;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_wait", cpu_ready, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", cpu_ready, 1);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            if (cpu_rvalid) nv++;
            @(negedge clk);
        end
        chk("abort_no_rvalid", nv, 0);

        do_read("rd_after_abort", 32'h0002_0000, 32'hCAFE_F00D, MEM_LAT + 1, 32'h0, 1'b0);
        do_write("wr_io3_mapped", 32'h0003_000C, 7'b0001000, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
